// File: rtl/vga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pkg : raster timing descriptor, standard presets, sizing helper
// Rev 1.0
// ---------------------------------------------------------------------------
package vga_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_timing_t;

  // Per-pixel control bits carried alongside the pixel through the pipeline
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_ctrl_t;

  localparam vga_timing_t VGA_640x480 = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam vga_timing_t VGA_800x600 = '{active: 800, fp: 40, sync: 128, bp: 88};

  function automatic int total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_delay_line : clock-enabled W-bit shift register, DEPTH >= 1 stages
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] stage_q;
  logic [DEPTH-1:0][W-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (ce) begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing_gen : VGA raster counters, pixel clock-enable and aligned output
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2,
  parameter int COLOR_W    = 8,
  localparam int H_TOTAL   = total(vga_timing_t'{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP}),
  localparam int V_TOTAL   = total(vga_timing_t'{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP}),
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 vgaclk,
  output logic                 pix_ce,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic                 req,
  output logic                 frame_start,
  input  logic [3*COLOR_W-1:0] rgb_in,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 sync_b,
  output logic                 blank_b,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HIGH = DW'((CLK_DIV + 1) / 2);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_E  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SYN_S  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SYN_E  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_E  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SYN_S  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SYN_E  = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]        div_q, div_d;
  logic                 pix_ce_q, pix_ce_d;
  logic                 vgaclk_q, vgaclk_d;
  logic [XW-1:0]        hcnt_q, hcnt_d;
  logic [YW-1:0]        vcnt_q, vcnt_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 blank_b_q, blank_b_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 active;
  logic                 advance;
  vga_ctrl_t            ctrl_raw;
  vga_ctrl_t            ctrl_dly;

  // pix_ce and vgaclk are registered so both read 0 in reset and the first
  // tick lands CLK_DIV clocks after release.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_ce_d = (div_q == DIV_LAST);
    vgaclk_d = (div_q < DIV_HIGH);
  end

  assign advance = pix_ce_q & enable;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (advance) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  assign active         = (hcnt_q < H_ACT_E) && (vcnt_q < V_ACT_E);
  assign ctrl_raw.active = active & enable;
  assign ctrl_raw.hs     = (hcnt_q >= H_SYN_S) && (hcnt_q < H_SYN_E);
  assign ctrl_raw.vs     = (vcnt_q >= V_SYN_S) && (vcnt_q < V_SYN_E);

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign ctrl_dly = ctrl_raw;
    end else begin : g_delay
      vga_delay_line #(
        .W     ($bits(vga_ctrl_t)),
        .DEPTH (PIPE_DELAY)
      ) u_ctrl_dly (
        .clk   (clk),
        .rst_n (reset),
        .ce    (pix_ce_q),
        .d     (ctrl_raw),
        .q     (ctrl_dly)
      );
    end
  endgenerate

  always_comb begin
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_b_d = blank_b_q;
    rgb_d     = rgb_q;
    if (pix_ce_q) begin
      hsync_d   = ctrl_dly.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_d   = ctrl_dly.vs ? VSYNC_POL : ~VSYNC_POL;
      blank_b_d = ctrl_dly.active;
      rgb_d     = ctrl_dly.active ? rgb_in : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      pix_ce_q  <= 1'b0;
      vgaclk_q  <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
      blank_b_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      div_q     <= div_d;
      pix_ce_q  <= pix_ce_d;
      vgaclk_q  <= vgaclk_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_b_q <= blank_b_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vgaclk      = vgaclk_q;
  assign pix_ce      = pix_ce_q;
  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign req         = active & advance;
  assign frame_start = advance & (hcnt_q == '0) & (vcnt_q == '0);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign sync_b      = 1'b0;
  assign blank_b     = blank_b_q;
  assign r           = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign g           = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign b           = rgb_q[COLOR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_timing_gen : directed checks on a tiny raster, a zero-latency
// active-high-hsync variant and the default 640x480 timing. Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Tiny raster: H 4/1/2/1 (8), V 3/1/1/1 (6), CLK_DIV 2, PIPE_DELAY 2
  logic        s_rst_n = 1'b0, s_en = 1'b1;
  logic [23:0] s_rgb = '0, s_h0 = '0, s_h1 = '0;
  logic        s_vgaclk, s_pix_ce, s_req, s_fs, s_hsync, s_vsync, s_sync_b, s_blank_b;
  logic [2:0]  s_x, s_y;
  logic [7:0]  s_r, s_g, s_b;

  // Same raster, HSYNC_POL 1, CLK_DIV 1, PIPE_DELAY 0
  logic        p_rst_n = 1'b0, p_en = 1'b1;
  logic [23:0] p_rgb;
  logic        p_vgaclk, p_pix_ce, p_req, p_fs, p_hsync, p_vsync, p_sync_b, p_blank_b;
  logic [2:0]  p_x, p_y;
  logic [7:0]  p_r, p_g, p_b;

  // Default parameters
  logic        d_rst_n = 1'b0, d_en = 1'b1;
  logic [23:0] d_rgb = 24'h123456;
  logic        d_vgaclk, d_pix_ce, d_req, d_fs, d_hsync, d_vsync, d_sync_b, d_blank_b;
  logic [9:0]  d_x, d_y;
  logic [7:0]  d_r, d_g, d_b;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(2), .PIPE_DELAY(2), .COLOR_W(8)
  ) u_small (
    .clk(clk), .reset(s_rst_n), .enable(s_en), .vgaclk(s_vgaclk), .pix_ce(s_pix_ce),
    .x(s_x), .y(s_y), .req(s_req), .frame_start(s_fs), .rgb_in(s_rgb),
    .hsync(s_hsync), .vsync(s_vsync), .sync_b(s_sync_b), .blank_b(s_blank_b),
    .r(s_r), .g(s_g), .b(s_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .CLK_DIV(1), .PIPE_DELAY(0), .COLOR_W(8)
  ) u_pol (
    .clk(clk), .reset(p_rst_n), .enable(p_en), .vgaclk(p_vgaclk), .pix_ce(p_pix_ce),
    .x(p_x), .y(p_y), .req(p_req), .frame_start(p_fs), .rgb_in(p_rgb),
    .hsync(p_hsync), .vsync(p_vsync), .sync_b(p_sync_b), .blank_b(p_blank_b),
    .r(p_r), .g(p_g), .b(p_b)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .reset(d_rst_n), .enable(d_en), .vgaclk(d_vgaclk), .pix_ce(d_pix_ce),
    .x(d_x), .y(d_y), .req(d_req), .frame_start(d_fs), .rgb_in(d_rgb),
    .hsync(d_hsync), .vsync(d_vsync), .sync_b(d_sync_b), .blank_b(d_blank_b),
    .r(d_r), .g(d_g), .b(d_b)
  );

  // Pixel source for u_small: answers each coordinate two ticks later
  always @(negedge clk) begin
    if (s_pix_ce) begin
      s_rgb = s_h1;
      s_h1  = s_h0;
      s_h0  = {5'b0, s_x, 5'b0, s_y, 8'hA5};
    end
  end

  assign p_rgb = {5'b0, p_x, 5'b0, p_y, 8'hA5};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ce_of(input int id);
    case (id)
      0:       return s_pix_ce;
      1:       return p_pix_ce;
      default: return d_pix_ce;
    endcase
  endfunction

  // Returns at the negedge of the next pixel tick, reporting clocks waited
  task automatic wait_tick(input int id, output int clks);
    clks = 0;
    do begin
      @(negedge clk);
      clks++;
    end while (!ce_of(id) && clks < 16);
    if (!ce_of(id)) check_eq("tick_seen", {63'b0, ce_of(id)}, 64'd1);
  endtask

  // Tiny raster, tick k of the frame: {x, y, req, frame_start}
  function automatic logic [7:0] s_exp_xy(input int k);
    int kk, ex, ey;
    kk = k % 48;
    ex = kk % 8;
    ey = kk / 8;
    return {3'(ex), 3'(ey), (ex < 4) && (ey < 3), kk == 0};
  endfunction

  // Tiny raster, active-low syncs: {hsync, vsync, blank_b, r, g, b} for coordinate c
  function automatic logic [26:0] s_exp_out(input int c);
    int cx, cy;
    logic act;
    if (c < 0) return {1'b1, 1'b1, 1'b0, 24'h0};
    cx  = c % 8;
    cy  = (c / 8) % 6;
    act = (cx < 4) && (cy < 3);
    return {!((cx == 5) || (cx == 6)), cy != 4, act,
            act ? 8'(cx) : 8'h00, act ? 8'(cy) : 8'h00, act ? 8'hA5 : 8'h00};
  endfunction

  // Tiny raster, hsync active-high: {vgaclk, hsync, vsync, blank_b, r, g, b}
  function automatic logic [27:0] p_exp_out(input int c);
    int cx, cy;
    logic act;
    if (c < 0) return {1'b1, 1'b0, 1'b1, 1'b0, 24'h0};
    cx  = c % 8;
    cy  = (c / 8) % 6;
    act = (cx < 4) && (cy < 3);
    return {1'b1, (cx == 5) || (cx == 6), cy != 4, act,
            act ? 8'(cx) : 8'h00, act ? 8'(cy) : 8'h00, act ? 8'hA5 : 8'h00};
  endfunction

  int clks;
  int hs_low, vs_low, blk, reqs, fss, bad, first_hs;

  initial begin
    repeat (25) @(negedge clk);
    check_eq("s_rst_flags", {s_vgaclk, s_pix_ce, s_req, s_fs, s_hsync, s_vsync, s_sync_b, s_blank_b}, 8'b0000_1100);
    check_eq("s_rst_data", {s_x, s_y, s_r, s_g, s_b}, 30'h0);
    check_eq("p_rst_flags", {p_vgaclk, p_pix_ce, p_req, p_fs, p_hsync, p_vsync, p_sync_b, p_blank_b}, 8'b0000_0100);

    // ---------------- tiny raster: two frames plus a bit ----------------
    s_rst_n = 1'b1;
    wait_tick(0, clks);
    check_eq("s_first_ce", clks, 2);
    hs_low = 0; vs_low = 0; blk = 0; reqs = 0; fss = 0;
    for (int k = 0; k < 106; k++) begin
      if (k > 0) begin
        wait_tick(0, clks);
        check_eq("s_ce_gap", clks, 2);
      end
      check_eq("s_xy", {s_x, s_y, s_req, s_fs}, s_exp_xy(k));
      check_eq("s_out", {s_hsync, s_vsync, s_blank_b, s_r, s_g, s_b}, s_exp_out(k - 3));
      if (k >= 3 && k <= 50) begin
        if (!s_hsync) hs_low++;
        if (!s_vsync) vs_low++;
        if (s_blank_b) blk++;
      end
      if (k < 48 && s_req) reqs++;
      if (k < 96 && s_fs) fss++;
    end
    check_eq("s_hsync_low_ticks", hs_low, 12);
    check_eq("s_vsync_low_ticks", vs_low, 8);
    check_eq("s_visible_ticks", blk, 12);
    check_eq("s_req_per_frame", reqs, 12);
    check_eq("s_frame_starts", fss, 2);

    // Last tick showed (1,1); freeze before (2,1) advances
    @(negedge clk);
    s_en = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      wait_tick(0, clks);
      check_eq("s_hold_xy", {s_x, s_y, s_req, s_fs}, {3'd2, 3'd1, 1'b0, 1'b0});
      case (j)
        1:       check_eq("s_hold_out", {s_hsync, s_vsync, s_blank_b, s_r, s_g, s_b}, s_exp_out(7));
        2:       check_eq("s_hold_out", {s_hsync, s_vsync, s_blank_b, s_r, s_g, s_b}, s_exp_out(8));
        3:       check_eq("s_hold_out", {s_hsync, s_vsync, s_blank_b, s_r, s_g, s_b}, s_exp_out(9));
        default: check_eq("s_hold_out", {s_hsync, s_vsync, s_blank_b, s_r, s_g, s_b}, s_exp_out(-1));
      endcase
    end
    @(negedge clk);
    s_en = 1'b1;
    for (int m = 0; m < 4; m++) begin
      wait_tick(0, clks);
      check_eq("s_resume_xy", {s_x, s_y, s_req, s_fs}, s_exp_xy(10 + m));
      check_eq("s_resume_out", {s_hsync, s_vsync, s_blank_b, s_r, s_g, s_b},
               (m == 3) ? s_exp_out(10) : s_exp_out(-1));
    end

    // Now mid-line at x=5: pulse reset for one clock
    check_eq("s_pre_reset_x", s_x, 3'd5);
    s_rst_n = 1'b0;
    #1;
    check_eq("s_async_flags", {s_vgaclk, s_pix_ce, s_req, s_fs, s_hsync, s_vsync, s_sync_b, s_blank_b}, 8'b0000_1100);
    check_eq("s_async_data", {s_x, s_y, s_r, s_g, s_b}, 30'h0);
    @(negedge clk);
    s_rst_n = 1'b1;
    wait_tick(0, clks);
    check_eq("s_restart_ce", clks, 2);
    check_eq("s_restart_xy", {s_x, s_y, s_req, s_fs}, s_exp_xy(0));
    check_eq("s_restart_out", {s_hsync, s_vsync, s_blank_b, s_r, s_g, s_b}, s_exp_out(-1));

    // ---------------- active-high hsync, one clk per pixel, no pipe ----------------
    p_rst_n = 1'b1;
    wait_tick(1, clks);
    check_eq("p_first_ce", clks, 1);
    for (int k = 0; k < 48; k++) begin
      if (k > 0) begin
        wait_tick(1, clks);
        check_eq("p_ce_gap", clks, 1);
      end
      check_eq("p_xy", {p_x, p_y, p_req, p_fs}, s_exp_xy(k));
      check_eq("p_out", {p_vgaclk, p_hsync, p_vsync, p_blank_b, p_r, p_g, p_b}, p_exp_out(k - 1));
    end

    // ---------------- default 640x480 timing, first two lines ----------------
    d_rst_n = 1'b1;
    wait_tick(2, clks);
    check_eq("d_first_ce", clks, 2);
    hs_low = 0; vs_low = 0; blk = 0; reqs = 0; fss = 0; bad = 0; first_hs = -1;
    for (int k = 0; k < 1603; k++) begin
      if (k > 0) wait_tick(2, clks);
      if (k == 0)    check_eq("d_xy_0", {d_x, d_y, d_fs}, {10'd0, 10'd0, 1'b1});
      if (k == 799)  check_eq("d_xy_799", {d_x, d_y}, {10'd799, 10'd0});
      if (k == 800)  check_eq("d_xy_800", {d_x, d_y}, {10'd0, 10'd1});
      if (k == 1600) check_eq("d_xy_1600", {d_x, d_y}, {10'd0, 10'd2});
      if (k < 800 && d_req) reqs++;
      if (k >= 3 && k <= 802) begin
        if (!d_hsync) hs_low++;
        if (d_blank_b) blk++;
      end
      if (!d_hsync && first_hs < 0) first_hs = k;
      if (!d_vsync) vs_low++;
      if (d_fs) fss++;
      if (!d_blank_b && {d_r, d_g, d_b} != 24'h0) bad++;
      if (d_blank_b && {d_r, d_g, d_b} != 24'h123456) bad++;
    end
    check_eq("d_req_per_line", reqs, 640);
    check_eq("d_hsync_low_ticks", hs_low, 96);
    check_eq("d_first_hsync_tick", first_hs, 659);
    check_eq("d_visible_ticks", blk, 640);
    check_eq("d_vsync_low_ticks", vs_low, 0);
    check_eq("d_frame_starts", fss, 1);
    check_eq("d_rgb_gating", bad, 0);
    check_eq("d_sync_b", d_sync_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
